// File: rtl/apb_master_bridge.sv
// Single-initiator APB master: decodes one CPU request into SETUP/ACCESS on the selected slave lane.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int unsigned NUM_SLV     = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd255
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   transfer,
    input  logic                   write,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic                   err,
    output logic                   busy,
    output logic [11:0]            PADDR,
    output logic [31:0]            PWDATA,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [NUM_SLV-1:0]     PSEL,
    input  logic [32*NUM_SLV-1:0]  PRDATA,
    input  logic [NUM_SLV-1:0]     PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e               state_q;
    logic [31:0]          rdata_q;
    logic                 ready_q;
    logic                 err_q;
    logic [11:0]          paddr_q;
    logic [31:0]          pwdata_q;
    logic                 pwrite_q;
    logic                 penable_q;
    logic [NUM_SLV-1:0]   psel_q;

    logic                 hit;
    logic                 pready_sel;
    logic                 tmo_hit;
    logic [31:0]          prdata_sel;

    assign hit = (addr[31:12] == BASE_ADDR[31:12]) && !addr[11] &&
                 ({29'd0, addr[10:8]} < NUM_SLV);

    // PSEL is one-hot, so masking with it selects exactly the addressed lane.
    assign pready_sel = |(PREADY & psel_q);

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (psel_q[i]) prdata_sel = prdata_sel | PRDATA[32*i +: 32];
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic [15:0] tmo_d;
    assign tmo_d   = tmo_q + 16'd1;
    assign tmo_hit = (tmo_d >= TIMEOUT_CYC);
`else
    localparam logic [15:0] tmo_unused = TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        paddr_q  <= addr[11:0];
                        pwdata_q <= wdata;
                        pwrite_q <= write;
                        if (hit) begin
                            psel_q  <= NUM_SLV'(1) << addr[10:8];
                            state_q <= SETUP;
                        end else begin
                            // Undecodable: complete locally, no APB activity.
                            rdata_q <= '0;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (pready_sel) begin
                        rdata_q   <= pwrite_q ? 32'h0 : prdata_sel;
                        ready_q   <= 1'b1;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (tmo_hit) begin
                        rdata_q   <= '0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                        tmo_q <= tmo_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;

endmodule
